// File: rtl/wb_regfile.sv
// Write-back stage register file: 16x16 GPRs with R0 hard-wired to zero,
// write-before-read bypass, sticky halt state and a retired-instruction counter.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg,
  input  logic        PCS,
  input  logic        WriteReg,
  input  logic        HLT,
  input  logic [3:0]  rd,
  input  logic [15:0] MemData,
  input  logic [15:0] AluOut,
  input  logic [15:0] PC,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2,
  output logic [15:0] WbData,
  output logic        WbEn,
  output logic        Halted,
  output logic [15:0] RetireCount
);

  typedef enum logic [0:0] {StRun, StHalted} stateT;

  stateT       stateQ, stateD;
  logic [15:0] retireCountQ, retireCountD;
  logic [15:0] regsQ [16];
  logic        running;
  logic        retire;

  assign running = (stateQ == StRun);
  // HLT and WriteReg in the same cycle still retire only one instruction.
  assign retire  = running && (WriteReg || HLT);

  // PC (link) has priority over memory data.
  always_comb begin
    WbData = AluOut;
    if (PCS) begin
      WbData = PC;
    end else if (MemtoReg) begin
      WbData = MemData;
    end
  end

  assign WbEn = WriteReg && (rd != 4'd0) && running && !HLT;

  function automatic logic [15:0] readPort(input logic [3:0] idx);
    logic [15:0] val;
    val = regsQ[idx];
    if (idx == 4'd0) begin
      val = 16'h0000;
    end else if (WbEn && (idx == rd)) begin
      val = WbData;
    end
    return val;
  endfunction

  always_comb begin
    SrcData1 = readPort(SrcReg1);
    SrcData2 = readPort(SrcReg2);
  end

  always_comb begin
    stateD       = stateQ;
    retireCountD = retireCountQ;
    if (running && HLT) begin
      stateD = StHalted;
    end
    if (retire) begin
      retireCountD = retireCountQ + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ       <= StRun;
      retireCountQ <= 16'h0000;
    end else begin
      stateQ       <= stateD;
      retireCountQ <= retireCountD;
    end
  end

  // R0 is only ever reset, never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regsQ[i] <= 16'h0000;
      end
    end else begin
      for (int i = 1; i < 16; i++) begin
        if (WbEn && (rd == 4'(i))) begin
          regsQ[i] <= WbData;
        end
      end
    end
  end

  assign Halted      = (stateQ == StHalted);
  assign RetireCount = retireCountQ;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, write-back select, R0, halt, wrap and async reset.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemtoReg, PCS, WriteReg, HLT;
  logic [3:0]  rd, SrcReg1, SrcReg2;
  logic [15:0] MemData, AluOut, PC;
  logic [15:0] SrcData1, SrcData2, WbData, RetireCount;
  logic        WbEn, Halted;

  int passCount  = 0;
  int checkCount = 0;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .MemtoReg   (MemtoReg),
    .PCS        (PCS),
    .WriteReg   (WriteReg),
    .HLT        (HLT),
    .rd         (rd),
    .MemData    (MemData),
    .AluOut     (AluOut),
    .PC         (PC),
    .SrcReg1    (SrcReg1),
    .SrcReg2    (SrcReg2),
    .SrcData1   (SrcData1),
    .SrcData2   (SrcData2),
    .WbData     (WbData),
    .WbEn       (WbEn),
    .Halted     (Halted),
    .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemtoReg = 1'b0; PCS = 1'b0; WriteReg = 1'b0; HLT = 1'b0;
    rd = 4'd0; MemData = 16'h0; AluOut = 16'h0; PC = 16'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    SrcReg1 = 4'd3; SrcReg2 = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_halted", {15'b0, Halted}, 16'h0000);
    check("reset_count", RetireCount, 16'h0000);
    check("reset_r3", SrcData1, 16'h0000);

    // ALU write to R3
    WriteReg = 1'b1; rd = 4'd3; AluOut = 16'h1234; MemData = 16'h9999; PC = 16'h7777;
    #1;
    check("alu_wbdata", WbData, 16'h1234);
    check("alu_wben", {15'b0, WbEn}, 16'h0001);
    tick();
    idle();
    SrcReg1 = 4'd3;
    #1;
    check("r3_stored", SrcData1, 16'h1234);
    check("count_1", RetireCount, 16'd1);

    // Dual-port bypass of memory data to R5
    WriteReg = 1'b1; rd = 4'd5; MemtoReg = 1'b1; MemData = 16'hBEEF; AluOut = 16'h0101;
    SrcReg1 = 4'd5; SrcReg2 = 4'd5;
    #1;
    check("bypass_p1", SrcData1, 16'hBEEF);
    check("bypass_p2", SrcData2, 16'hBEEF);
    tick();
    idle();
    SrcReg2 = 4'd3;
    #1;
    check("r5_stored", SrcData1, 16'hBEEF);
    check("r3_port2", SrcData2, 16'h1234);
    check("count_2", RetireCount, 16'd2);

    // Write to R0 is suppressed but retires
    WriteReg = 1'b1; rd = 4'd0; AluOut = 16'hFFFF; SrcReg1 = 4'd0;
    #1;
    check("r0_wben", {15'b0, WbEn}, 16'h0000);
    check("r0_read", SrcData1, 16'h0000);
    tick();
    idle();
    #1;
    check("r0_after", SrcData1, 16'h0000);
    check("count_3", RetireCount, 16'd3);

    // PCS beats MemtoReg
    WriteReg = 1'b1; rd = 4'd15; PCS = 1'b1; MemtoReg = 1'b1;
    PC = 16'h0042; MemData = 16'h1111; AluOut = 16'h2222;
    #1;
    check("pcs_wbdata", WbData, 16'h0042);
    tick();
    idle();
    SrcReg1 = 4'd15;
    #1;
    check("r15_stored", SrcData1, 16'h0042);
    check("count_4", RetireCount, 16'd4);

    // Seed R2, then halt with a concurrent write to R2
    WriteReg = 1'b1; rd = 4'd2; AluOut = 16'h5555;
    tick();
    idle();
    WriteReg = 1'b1; HLT = 1'b1; rd = 4'd2; AluOut = 16'hAAAA; SrcReg1 = 4'd2;
    #1;
    check("hlt_wben", {15'b0, WbEn}, 16'h0000);
    check("hlt_nobypass", SrcData1, 16'h5555);
    check("hlt_not_yet", {15'b0, Halted}, 16'h0000);
    tick();
    idle();
    #1;
    check("halted_set", {15'b0, Halted}, 16'h0001);
    check("r2_kept", SrcData1, 16'h5555);
    check("count_hlt", RetireCount, 16'd6);

    // Writes and halts ignored while halted
    WriteReg = 1'b1; HLT = 1'b1; rd = 4'd2; AluOut = 16'h7777;
    #1;
    check("halted_wben", {15'b0, WbEn}, 16'h0000);
    tick();
    tick();
    #1;
    check("halted_r2", SrcData1, 16'h5555);
    check("halted_count", RetireCount, 16'd6);
    check("halted_sticky", {15'b0, Halted}, 16'h0001);

    // Asynchronous reset between edges
    #1;
    rst = 1'b1;
    #1;
    check("arst_halted", {15'b0, Halted}, 16'h0000);
    check("arst_count", RetireCount, 16'h0000);
    check("arst_r2", SrcData1, 16'h0000);
    SrcReg1 = 4'd15; SrcReg2 = 4'd3;
    #1;
    check("arst_r15", SrcData1, 16'h0000);
    check("arst_r3", SrcData2, 16'h0000);

    // Held in reset: no writes, no counting
    idle();
    WriteReg = 1'b1; rd = 4'd4; AluOut = 16'h4444; SrcReg1 = 4'd4;
    tick();
    tick();
    WriteReg = 1'b0;
    #1;
    check("inrst_r4", SrcData1, 16'h0000);
    check("inrst_count", RetireCount, 16'h0000);
    rst = 1'b0;

    // 65536 retirements wrap the counter
    WriteReg = 1'b1; rd = 4'd0;
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    check("count_ffff", RetireCount, 16'hFFFF);
    tick();
    check("count_wrap", RetireCount, 16'h0000);

    // Normal operation after wrap
    rd = 4'd7; AluOut = 16'hC0DE; SrcReg1 = 4'd7;
    tick();
    idle();
    #1;
    check("r7_after_wrap", SrcData1, 16'hC0DE);
    check("count_after_wrap", RetireCount, 16'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
